// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with binary/MFSR sequencing and a circular return-address stack
module pc_stack_unit #(
  parameter int               WIDTH     = 10,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_ADR = '0,
  parameter int               USEMFSR   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] pc,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [31:0] TAPS32 = WIDTH == 8  ? 32'h0000_00B8 :
                                   WIDTH == 10 ? 32'h0000_0240 :
                                   WIDTH == 12 ? 32'h0000_0829 :
                                   WIDTH == 16 ? 32'h0000_D008 : 32'h0;
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(TAPS32);
  if (USEMFSR != 0 && TAPS32 == 32'h0) begin : g_bad_width
    $error("pc_stack_unit: USEMFSR requires WIDTH of 8, 10, 12 or 16");
  end
  logic [WIDTH-1:0] stk [DEPTH];
  logic [PW-1:0]    tp, tp_inc, tp_dec;
  logic [LW-1:0]    lvl;
  logic [WIDTH-1:0] nxt, pc_n;
  logic             do_ret, do_call, do_load;
  assign empty = lvl == '0;
  assign full  = lvl == LW'(DEPTH);
  // resolve ret > call > load > increment and the circular pointer neighbours
  always_comb begin
    do_ret  = enable & ret;
    do_call = enable & ~ret & call;
    do_load = enable & ~ret & ~call & load;
    nxt     = (USEMFSR != 0) ? {pc[WIDTH-2:0], ~^(pc & TAPS)} : pc + WIDTH'(1);
    tp_inc  = (tp == PW'(DEPTH - 1)) ? '0 : tp + PW'(1);
    tp_dec  = (tp == '0) ? PW'(DEPTH - 1) : tp - PW'(1);
    pc_n    = (do_ret & ~empty) ? stk[tp] : (do_call | do_load) ? data : enable ? nxt : pc;
  end
  // pc, stack pointer, saturating level and sticky error flags
  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_ADR;
      tp        <= '0;
      lvl       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc <= pc_n;
      if (do_call) begin
        tp       <= tp_inc;
        lvl      <= full ? lvl : lvl + LW'(1);
        overflow <= overflow | full;
      end
      if (do_ret) begin
        tp        <= empty ? tp : tp_dec;
        lvl       <= empty ? lvl : lvl - LW'(1);
        underflow <= underflow | empty;
      end
    end
  end
  // stack entries carry no reset; the level alone says which are valid
  always_ff @(posedge clock) begin
    if (!reset && do_call) stk[tp_inc] <= nxt;
  end
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: randomized and directed checks of pc_stack_unit against a queue-based model
module tb_pc_stack_unit;
  logic       clock = 1'b0;
  logic       reset, enable, load, call, ret;
  logic [7:0] data, pc_b, pc_f;
  logic       empty_b, full_b, ovf_b, unf_b;
  logic       empty_f, full_f, ovf_f, unf_f;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] pc_m, mm;
  logic [7:0] stk_m [$];
  bit         ovf_m, unf_m;
  bit [255:0] seen;
  always #5 clock = ~clock;
  pc_stack_unit #(.WIDTH(8), .DEPTH(4), .RESET_ADR(8'h00), .USEMFSR(0)) dut_bin (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .call(call), .ret(ret),
    .data(data), .pc(pc_b), .empty(empty_b), .full(full_b), .overflow(ovf_b), .underflow(unf_b)
  );
  pc_stack_unit #(.WIDTH(8), .DEPTH(4), .RESET_ADR(8'h00), .USEMFSR(1)) dut_mfsr (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .call(call), .ret(ret),
    .data(data), .pc(pc_f), .empty(empty_f), .full(full_f), .overflow(ovf_f), .underflow(unf_f)
  );
  function automatic logic [7:0] inc8(input logic [7:0] v);
    return v + 8'd1;
  endfunction
  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic drive(input logic r, input logic e, input logic l, input logic c, input logic t, input logic [7:0] d);
    reset = r;
    enable = e;
    load = l;
    call = c;
    ret = t;
    data = d;
  endtask
  task automatic model_tick();
    if (reset) begin
      pc_m = 8'h00;
      stk_m.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else if (enable) begin
      if (ret) begin
        if (stk_m.size() == 0) begin
          unf_m = 1'b1;
          pc_m = inc8(pc_m);
        end else pc_m = stk_m.pop_back();
      end else if (call) begin
        if (stk_m.size() == 4) begin
          ovf_m = 1'b1;
          void'(stk_m.pop_front());
        end
        stk_m.push_back(inc8(pc_m));
        pc_m = data;
      end else if (load) pc_m = data;
      else pc_m = inc8(pc_m);
    end
  endtask
  task automatic step();
    model_tick();
    @(posedge clock);
    #1;
    check("pc", 32'(pc_b), 32'(pc_m));
    check("empty", 32'(empty_b), 32'(stk_m.size() == 0));
    check("full", 32'(full_b), 32'(stk_m.size() == 4));
    check("overflow", 32'(ovf_b), 32'(ovf_m));
    check("underflow", 32'(unf_b), 32'(unf_m));
  endtask
  initial begin
    logic [7:0] tgt [5];
    logic [7:0] rets [4];
    tgt = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    rets = '{8'h51, 8'h41, 8'h31, 8'h21};
    drive(1, 0, 0, 0, 0, 8'h00);
    step();
    check("reset_pc", 32'(pc_b), 0);
    check("reset_empty", 32'(empty_b), 1);
    // binary count with wrap
    for (int i = 1; i <= 257; i++) begin
      drive(0, 1, 0, 0, 0, 8'h00);
      step();
      check("bin_seq", 32'(pc_b), i % 256);
    end
    // MFSR sequence: starts 01,03,07, period 255, never all-ones
    drive(1, 0, 0, 0, 0, 8'h00);
    step();
    mm = 8'h00;
    check("mfsr_reset_pc", 32'(pc_f), 0);
    check("mfsr_reset_flags", {28'd0, empty_f, full_f, ovf_f, unf_f}, 32'h8);
    seen = '0;
    seen[0] = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      drive(0, 1, 0, 0, 0, 8'h00);
      step();
      mm = {mm[6:0], ~^(mm & 8'hB8)};
      check("mfsr_pc", 32'(pc_f), 32'(mm));
      if (i <= 3) check("mfsr_start", 32'(pc_f), (1 << i) - 1);
      if (i < 255) begin
        check("mfsr_unique", 32'(seen[pc_f]), 0);
        seen[pc_f] = 1'b1;
      end
      check("mfsr_not_ff", 32'(pc_f == 8'hFF), 0);
    end
    check("mfsr_period", 32'(pc_f), 0);
    // call / two incs / ret from 0x10
    drive(1, 0, 0, 0, 0, 8'h00);
    step();
    drive(0, 1, 1, 0, 0, 8'h10);
    step();
    drive(0, 1, 0, 1, 0, 8'h80);
    step();
    check("call_pc", 32'(pc_b), 32'h80);
    check("call_empty", 32'(empty_b), 0);
    drive(0, 1, 0, 0, 0, 8'h00);
    step();
    step();
    check("inc_pc", 32'(pc_b), 32'h82);
    drive(0, 1, 0, 0, 1, 8'h00);
    step();
    check("ret_pc", 32'(pc_b), 32'h11);
    check("ret_empty", 32'(empty_b), 1);
    // five calls from 0x05 overflow the 4-deep stack
    drive(0, 1, 1, 0, 0, 8'h05);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1, 0, tgt[i]);
      step();
      check("ovf_call_pc", 32'(pc_b), 32'(tgt[i]));
      check("ovf_full", 32'(full_b), 32'(i >= 3));
      check("ovf_flag", 32'(ovf_b), 32'(i == 4));
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 1, 8'h00);
      step();
      check("ovf_ret_pc", 32'(pc_b), 32'(rets[i]));
    end
    check("ovf_drained", 32'(empty_b), 1);
    // ret while empty, then stalled call
    drive(0, 1, 1, 0, 0, 8'h33);
    step();
    drive(0, 1, 0, 0, 1, 8'h00);
    step();
    check("unf_pc", 32'(pc_b), 32'h34);
    check("unf_flag", 32'(unf_b), 1);
    drive(0, 0, 0, 1, 0, 8'h99);
    step();
    step();
    check("stall_pc", 32'(pc_b), 32'h34);
    check("stall_empty", 32'(empty_b), 1);
    check("stall_unf", 32'(unf_b), 1);
    // simultaneous ret+call+load, then reset clears everything
    drive(0, 1, 1, 0, 0, 8'h43);
    step();
    drive(0, 1, 0, 1, 0, 8'h70);
    step();
    drive(0, 1, 1, 1, 1, 8'h99);
    step();
    check("prio_pc", 32'(pc_b), 32'h44);
    drive(1, 1, 1, 1, 1, 8'h99);
    step();
    check("rst_pc", 32'(pc_b), 0);
    check("rst_flags", {28'd0, empty_b, full_b, ovf_b, unf_b}, 32'h8);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(63) == 0, $urandom_range(7) != 0, $urandom_range(3) == 0,
            $urandom_range(4) == 0, $urandom_range(4) == 0, 8'($urandom));
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
